loteria_param: RTL

- Parametrised lottery-ticket checker, successor to the fixed five-digit game block.
- The player enters NUM_DIGITS digits one at a time (edge-triggered insert), can undo the last digit, then finishes.
- The block counts positional matches against a secret latched at finish, one digit per cycle, and maps the count to a prize tier.
- Outputs feed the board display/LED layer, which decodes digits, tier and win.

---
 rtl/loteria_pkg.sv | 26 ++
 rtl/loteria_param_edge_pulse.sv | 26 ++
 rtl/loteria_param.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/loteria_pkg.sv
// Shared definitions for the loteria_param lottery-ticket checker.
//   state_t        : controller state, also exported on the top-level debug port
//   DEF_DIGIT_W    : default bits per digit
//   DEF_MAX_DIGIT  : default largest legal digit value
//   tier_of()      : maps a match count to a prize tier
package loteria_pkg;

   typedef enum logic [1:0] {
      ENTRY  = 2'd0,
      CHECK  = 2'd1,
      RESULT = 2'd2
   } state_t;

   localparam int DEF_DIGIT_W   = 4;
   localparam int DEF_MAX_DIGIT = 9;

   // Only the top NUM_TIERS match counts pay out.
   // A full match always lands on the highest tier.
   function automatic int tier_of(input int m, input int nd, input int nt);
      if (m > nd - nt)
         return m - (nd - nt);
      else
         return 0;
   endfunction

endpackage

// File: rtl/loteria_param_edge_pulse.sv
// Rising-edge detector for a level input.
//   clk   : clock
//   reset : synchronous active-high reset, clears the history register
//   level : level input
//   pulse : high in the cycle where level is high and was low on the previous edge
// The pulse is combinational from the current level.
// The owner therefore acts on it at the same clock edge that samples the level.
module edge_pulse (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic pulse
);

   logic level_q;

   always_ff @(posedge clk) begin
      if (reset)
         level_q <= 1'b0;
      else
         level_q <= level;
   end

   assign pulse = level & ~level_q;

endmodule

// File: rtl/loteria_param.sv
// Parametrised lottery-ticket checker.
// Digits are entered one per insert edge and the last digit can be undone.
// On a finish edge the secret is latched.
// Positional matches are then counted one digit per cycle and mapped to a prize tier.
//   clk, reset  : clock, synchronous active-high reset
//   num         : digit to insert
//   insert      : rising edge inserts num
//   undo        : rising edge removes the last digit
//   finish      : rising edge starts the check
//   secret      : winning number, digit i at [i*DIGIT_W +: DIGIT_W]
//   digits      : entered digits, same packing; digit 0 is the first inserted
//   count       : digits entered so far
//   reject      : one-cycle pulse on an illegal action
//   busy / done : high in CHECK / RESULT
//   match_count : positional matches, valid while done
//   prize, win  : prize tier and (prize != 0), valid while done
//   state_dbg   : current controller state (debug)
module loteria_param
   import loteria_pkg::*;
#(
   parameter  int NUM_DIGITS = 5,
   parameter  int DIGIT_W    = DEF_DIGIT_W,
   parameter  int MAX_DIGIT  = DEF_MAX_DIGIT,
   parameter  int NUM_TIERS  = 3,
   localparam int CW         = $clog2(NUM_DIGITS + 1),
   localparam int PW         = $clog2(NUM_TIERS + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DIGIT_W-1:0]            num,
   input  logic                          insert,
   input  logic                          undo,
   input  logic                          finish,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] secret,
   output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
   output logic [CW-1:0]                 count,
   output logic                          reject,
   output logic                          busy,
   output logic                          done,
   output logic [CW-1:0]                 match_count,
   output logic [PW-1:0]                 prize,
   output logic                          win,
   output logic [1:0]                    state_dbg
);

   localparam logic [CW-1:0]      ND_C   = CW'(NUM_DIGITS);
   localparam logic [CW-1:0]      LAST_C = CW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0]      ONE_C  = CW'(1);
   localparam logic [DIGIT_W-1:0] MAX_C  = DIGIT_W'(MAX_DIGIT);

   state_t state, next_state;

   logic insert_ev, undo_ev, finish_ev;

   logic [NUM_DIGITS*DIGIT_W-1:0] digits_r, secret_r;
   logic [CW-1:0]                 count_r, idx_r, acc_r, match_r;
   logic [PW-1:0]                 prize_r;
   logic                          reject_r;

   logic          hit;
   logic [CW-1:0] acc_next;

   edge_pulse u_insert_edge (.clk(clk), .reset(reset), .level(insert), .pulse(insert_ev));
   edge_pulse u_undo_edge   (.clk(clk), .reset(reset), .level(undo),   .pulse(undo_ev));
   edge_pulse u_finish_edge (.clk(clk), .reset(reset), .level(finish), .pulse(finish_ev));

   // One positional compare per CHECK cycle.
   assign hit      = digits_r[idx_r*DIGIT_W +: DIGIT_W] == secret_r[idx_r*DIGIT_W +: DIGIT_W];
   assign acc_next = acc_r + CW'(hit);

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         state <= ENTRY;
      else
         state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         ENTRY:   if (finish_ev && count_r == ND_C) next_state = CHECK;
         CHECK:   if (idx_r == LAST_C)              next_state = RESULT;
         RESULT:  if (insert_ev)                    next_state = ENTRY;
         default: next_state = ENTRY;
      endcase
   end

   // Datapath. Within ENTRY, finish outranks undo, which outranks insert.
   // A losing event is dropped without a reject.
   always_ff @(posedge clk) begin
      if (reset) begin
         digits_r <= '0;
         secret_r <= '0;
         count_r  <= '0;
         idx_r    <= '0;
         acc_r    <= '0;
         match_r  <= '0;
         prize_r  <= '0;
         reject_r <= 1'b0;
      end else begin
         reject_r <= 1'b0;
         case (state)
            ENTRY: begin
               if (finish_ev) begin
                  if (count_r == ND_C) begin
                     secret_r <= secret;
                     idx_r    <= '0;
                     acc_r    <= '0;
                  end else begin
                     reject_r <= 1'b1;
                  end
               end else if (undo_ev) begin
                  if (count_r == '0) begin
                     reject_r <= 1'b1;
                  end else begin
                     count_r <= count_r - ONE_C;
                     digits_r[(count_r - ONE_C)*DIGIT_W +: DIGIT_W] <= '0;
                  end
               end else if (insert_ev) begin
                  if (num > MAX_C || count_r == ND_C) begin
                     reject_r <= 1'b1;
                  end else begin
                     digits_r[count_r*DIGIT_W +: DIGIT_W] <= num;
                     count_r <= count_r + ONE_C;
                  end
               end
            end
            CHECK: begin
               acc_r <= acc_next;
               if (idx_r == LAST_C) begin
                  idx_r   <= '0;
                  match_r <= acc_next;
                  prize_r <= PW'(tier_of(int'(acc_next), NUM_DIGITS, NUM_TIERS));
               end else begin
                  idx_r <= idx_r + ONE_C;
               end
            end
            RESULT: begin
               // A new ticket starts here.
               // The same insert edge is treated as the first digit of the new ticket.
               if (insert_ev) begin
                  digits_r <= '0;
                  match_r  <= '0;
                  prize_r  <= '0;
                  if (num > MAX_C) begin
                     count_r  <= '0;
                     reject_r <= 1'b1;
                  end else begin
                     digits_r[0 +: DIGIT_W] <= num;
                     count_r <= ONE_C;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Output logic
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         CHECK:   busy = 1'b1;
         RESULT:  done = 1'b1;
         default: ;
      endcase
      win = done & (prize_r != '0);
   end

   assign digits      = digits_r;
   assign count       = count_r;
   assign reject      = reject_r;
   assign match_count = match_r;
   assign prize       = prize_r;
   assign state_dbg   = state;

endmodule
